// File: rtl/exc_arbiter.sv
// MEM-stage exception arbiter: synchronises interrupt lines, picks the
// highest-priority exception of the MEM instruction, pulses a one-cycle CP0
// commit and holds a redirect PC toward fetch until it is acknowledged.
module exc_arbiter #(
    parameter logic [31:0] EXC_VEC  = 32'hBFC0_0380,
    parameter int          SYNC_STG = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_m,
    input  logic        valid_m,
    input  logic [31:0] pc_m,
    input  logic        slot_m,
    input  logic [7:0]  exc_flags_m,
    input  logic [31:0] daddr_m,
    input  logic [5:0]  ext_int,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    input  logic        if_ack,
    output logic        cp0_en,
    output logic [4:0]  cp0_exctype,
    output logic [31:0] cp0_pc,
    output logic [31:0] cp0_badvaddr,
    output logic        cp0_slot,
    output logic [5:0]  hw_int,
    output logic        flush,
    output logic        redir_valid,
    output logic [31:0] redir_pc
);

    typedef enum logic {IDLE, REDIR} state_t;

    state_t                     state;
    logic [SYNC_STG-1:0][5:0]   sync_pipe;
    logic                       int_req;
    logic                       take;
    logic                       is_eret;
    logic [4:0]                 code;
    logic [31:0]                badv;
    logic                       unused_ok;

    // Only Status IM/IE/EXL and Cause IP[1:0] matter here.
    assign unused_ok = ^{cp0_status[31:16], cp0_status[7:2],
                         cp0_cause[31:10], cp0_cause[7:0]};

    // Metastability chain on the async interrupt lines; stage 0 is the first flop.
    always_ff @(posedge clk) begin
        if (rst) sync_pipe <= '0;
        else     sync_pipe <= {sync_pipe[SYNC_STG-2:0], ext_int};
    end

    assign hw_int = sync_pipe[SYNC_STG-1];

    assign int_req = (|({hw_int, cp0_cause[9:8]} & cp0_status[15:8]))
                     & cp0_status[0] & ~cp0_status[1];

    // Held in reset the arbiter must not commit anything.
    assign take = ~rst & valid_m & ~stall_m & (state == IDLE)
                  & (int_req | (|exc_flags_m));

    // Fixed-priority pick of the single reported cause.
    always_comb begin
        code    = 5'h00;
        badv    = 32'h0;
        is_eret = 1'b0;
        if (int_req)             code = 5'h00;
        else if (exc_flags_m[0]) begin code = 5'h04; badv = pc_m; end
        else if (exc_flags_m[1]) code = 5'h0a;
        else if (exc_flags_m[2]) code = 5'h08;
        else if (exc_flags_m[3]) code = 5'h09;
        else if (exc_flags_m[4]) code = 5'h0c;
        else if (exc_flags_m[5]) begin code = 5'h04; badv = daddr_m; end
        else if (exc_flags_m[6]) begin code = 5'h05; badv = daddr_m; end
        else if (exc_flags_m[7]) begin code = 5'h0e; is_eret = 1'b1; end
    end

    assign cp0_en       = take;
    assign cp0_exctype  = take ? code : 5'h00;
    assign cp0_pc       = take ? pc_m : 32'h0;
    assign cp0_badvaddr = take ? badv : 32'h0;
    assign cp0_slot     = take & slot_m;
    assign flush        = take | (state != IDLE);

    // Redirect FSM: latch target on take, hold it until fetch acknowledges.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            redir_valid <= 1'b0;
            redir_pc    <= 32'h0;
        end else begin
            case (state)
                IDLE: if (take) begin
                    state       <= REDIR;
                    redir_valid <= 1'b1;
                    redir_pc    <= is_eret ? cp0_epc : EXC_VEC;
                end
                REDIR: if (if_ack) begin
                    state       <= IDLE;
                    redir_valid <= 1'b0;
                    redir_pc    <= 32'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exc_arbiter.sv
// Bench for exc_arbiter: directed scenarios followed by random traffic, all
// outputs compared every cycle against a cycle-level behavioural model.
module tb_exc_arbiter;

    localparam logic [31:0] VEC = 32'hBFC0_0380;
    localparam int          SS  = 2;

    logic        clk = 1'b0;
    logic        rst, stall_m, valid_m, slot_m, if_ack;
    logic [31:0] pc_m, daddr_m, cp0_status, cp0_cause, cp0_epc;
    logic [7:0]  exc_flags_m;
    logic [5:0]  ext_int;
    logic        cp0_en, cp0_slot, flush, redir_valid;
    logic [4:0]  cp0_exctype;
    logic [31:0] cp0_pc, cp0_badvaddr, redir_pc;
    logic [5:0]  hw_int;

    exc_arbiter #(.EXC_VEC(VEC), .SYNC_STG(SS)) dut (
        .clk(clk), .rst(rst), .stall_m(stall_m), .valid_m(valid_m), .pc_m(pc_m),
        .slot_m(slot_m), .exc_flags_m(exc_flags_m), .daddr_m(daddr_m),
        .ext_int(ext_int), .cp0_status(cp0_status), .cp0_cause(cp0_cause),
        .cp0_epc(cp0_epc), .if_ack(if_ack), .cp0_en(cp0_en),
        .cp0_exctype(cp0_exctype), .cp0_pc(cp0_pc), .cp0_badvaddr(cp0_badvaddr),
        .cp0_slot(cp0_slot), .hw_int(hw_int), .flush(flush),
        .redir_valid(redir_valid), .redir_pc(redir_pc)
    );

    always #5 clk = ~clk;

    int npass = 0, ntot = 0, nfail = 0;

    // Reference state: history of sampled ext_int, redirect pending, target.
    logic [5:0]  syncq[$];
    bit          m_busy;
    logic [31:0] m_tgt;
    logic [4:0]  codes[8] = '{5'h04, 5'h0a, 5'h08, 5'h09, 5'h0c, 5'h04, 5'h05, 5'h0e};

    // Outputs captured at the last check point, for directed checks.
    logic        s_en, s_flush, s_rv;
    logic [4:0]  s_type;
    logic [31:0] s_badv, s_rpc;
    logic [5:0]  s_hw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        syncq.delete();
        for (int i = 0; i < SS; i++) syncq.push_back(6'h0);
        m_busy = 1'b0;
        m_tgt  = 32'h0;
    endtask

    // One clock: compare at negedge against the model, then advance the model.
    task automatic cyc();
        logic [5:0]  mhw;
        logic        intr, tk, eret;
        logic [4:0]  ec;
        logic [31:0] bv;
        @(negedge clk);
        mhw  = syncq[0];
        intr = (|({mhw, cp0_cause[9:8]} & cp0_status[15:8])) && cp0_status[0] && !cp0_status[1];
        ec = 5'h0; bv = 32'h0; eret = 1'b0;
        if (!intr)
            for (int i = 7; i >= 0; i--)
                if (exc_flags_m[i]) begin
                    ec   = codes[i];
                    eret = (i == 7);
                    bv   = (i == 0) ? pc_m : ((i == 5 || i == 6) ? daddr_m : 32'h0);
                end
        tk = !rst && valid_m && !stall_m && !m_busy && (intr || exc_flags_m != 8'h0);
        s_en = cp0_en; s_type = cp0_exctype; s_badv = cp0_badvaddr;
        s_flush = flush; s_rv = redir_valid; s_rpc = redir_pc; s_hw = hw_int;
        chk("cp0_en", cp0_en, tk);
        chk("exctype", cp0_exctype, tk ? ec : 5'h0);
        chk("cp0_pc", cp0_pc, tk ? pc_m : 32'h0);
        chk("badvaddr", cp0_badvaddr, tk ? bv : 32'h0);
        chk("cp0_slot", cp0_slot, tk & slot_m);
        chk("hw_int", hw_int, mhw);
        chk("flush", flush, tk | m_busy);
        chk("redir_valid", redir_valid, m_busy);
        chk("redir_pc", redir_pc, m_busy ? m_tgt : 32'h0);
        @(posedge clk);
        if (rst) model_reset();
        else begin
            syncq.push_back(ext_int);
            void'(syncq.pop_front());
            if (m_busy && if_ack) begin m_busy = 1'b0; m_tgt = 32'h0; end
            else if (tk) begin m_busy = 1'b1; m_tgt = eret ? cp0_epc : VEC; end
        end
        #1;
    endtask

    task automatic ack();
        if_ack = 1'b1; cyc(); if_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall_m = 1'b0; valid_m = 1'b0; slot_m = 1'b0; if_ack = 1'b0;
        pc_m = 32'h0; daddr_m = 32'h0; exc_flags_m = 8'h0; ext_int = 6'h0;
        cp0_status = 32'h0; cp0_cause = 32'h0; cp0_epc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cyc();
        chk("reset_redir_valid", s_rv, 1'b0);
        rst = 1'b0;
        cyc();

        // SYSCALL in MEM
        valid_m = 1'b1; exc_flags_m = 8'h04; pc_m = 32'h8000_0100; slot_m = 1'b1;
        cyc();
        chk("sys_en", s_en, 1'b1);
        chk("sys_type", s_type, 5'h08);
        valid_m = 1'b0; exc_flags_m = 8'h0; slot_m = 1'b0;
        repeat (2) cyc();
        chk("sys_redir_pc", s_rpc, VEC);
        chk("sys_en_once", s_en, 1'b0);
        ack();
        cyc();
        chk("sys_idle_rpc", s_rpc, 32'h0);

        // Data ADEL beats ADES
        valid_m = 1'b1; exc_flags_m = 8'h60; daddr_m = 32'h0000_1001;
        cyc();
        chk("adel_type", s_type, 5'h04);
        chk("adel_badv", s_badv, 32'h0000_1001);
        valid_m = 1'b0; exc_flags_m = 8'h0;
        ack();

        // Interrupt: waits on bubbles, then beats RI
        cp0_status = 32'h0000_0401; ext_int = 6'h01;
        repeat (3) cyc();
        chk("int_hw", s_hw, 6'h01);
        chk("int_bubble_en", s_en, 1'b0);
        valid_m = 1'b1; exc_flags_m = 8'h02;
        cyc();
        chk("int_type", s_type, 5'h00);
        chk("int_en", s_en, 1'b1);
        valid_m = 1'b0; exc_flags_m = 8'h0; ext_int = 6'h0; cp0_status = 32'h0;
        ack();

        // ERET with delayed ack
        valid_m = 1'b1; exc_flags_m = 8'h80; cp0_epc = 32'h8000_0200;
        cyc();
        chk("eret_type", s_type, 5'h0e);
        valid_m = 1'b0; exc_flags_m = 8'h0; cp0_epc = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("eret_hold_flush", s_flush, 1'b1);
            chk("eret_hold_pc", s_rpc, 32'h8000_0200);
        end
        ack();

        // Stall holds off the commit
        valid_m = 1'b1; exc_flags_m = 8'h04; stall_m = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_en", s_en, 1'b0);
        end
        stall_m = 1'b0;
        cyc();
        chk("stall_release_en", s_en, 1'b1);
        valid_m = 1'b0; exc_flags_m = 8'h0;
        cyc();

        // Reset in REDIR, then EXL masks the interrupt
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        chk("rst_redir_valid", s_rv, 1'b0);
        chk("rst_flush", s_flush, 1'b0);
        cp0_status = 32'h0000_0403; ext_int = 6'h01;
        repeat (3) cyc();
        valid_m = 1'b1;
        cyc();
        chk("exl_block_en", s_en, 1'b0);
        valid_m = 1'b0; ext_int = 6'h0;

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            rst         = ($urandom_range(0, 59) == 0);
            valid_m     = ($urandom_range(0, 3) != 0);
            stall_m     = ($urandom_range(0, 3) == 0);
            slot_m      = $urandom_range(0, 1);
            pc_m        = $urandom;
            daddr_m     = $urandom;
            cp0_epc     = $urandom;
            exc_flags_m = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h0;
            if ($urandom_range(0, 7) == 0) ext_int = 6'($urandom);
            cp0_status  = {16'h0, 8'($urandom), 6'h0,
                           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0)};
            cp0_cause   = {22'h0, 2'($urandom), 8'h0};
            if_ack      = ($urandom_range(0, 2) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
